// File: rtl/rom4_16x8_if.sv
// Read port bundle for the hex-digit 7-segment lookup ROM.
// The master drives the address; the ROM slave returns combinational, registered and change-strobe outputs.
interface rom4_16x8_if;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] data_q;
    logic       addr_chg;

    modport master (
        output addr,
        input  data,
        input  data_q,
        input  addr_chg
    );

    modport slave (
        input  addr,
        output data,
        output data_q,
        output addr_chg
    );
endinterface

// File: rtl/rom4_16x8.sv
// 16x8 constant ROM mapping a hex digit to its 7-segment pattern {dp,g,f,e,d,c,b,a}.
// Zero-latency combinational read, plus a registered copy and an address-change strobe.
module rom4_16x8 #(
    parameter bit          INVERT  = 1'b0,
    parameter logic [15:0] DP_MASK = 16'h0000
) (
    input  logic         sysclk,
    input  logic         rst_n,
    rom4_16x8_if.slave   bus
);

    // Entry 0 sits in the least significant byte.
    localparam logic [16*8-1:0] TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    logic [7:0] rom_word [16];
    logic [7:0] data_next;
    logic [7:0] data_q_reg;
    logic [3:0] addr_q_reg;
    logic       addr_chg_reg;

    // Decimal point is merged before inversion so active-low displays see it lit as a 0.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_word
            assign rom_word[gi] = (TABLE[gi*8 +: 8] | {DP_MASK[gi], 7'b000_0000})
                                  ^ {8{INVERT}};
        end
    endgenerate

    always_comb begin
        data_next = rom_word[bus.addr];
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            data_q_reg   <= 8'h00;
            addr_q_reg   <= 4'h0;
            addr_chg_reg <= 1'b0;
        end else begin
            data_q_reg   <= data_next;
            addr_q_reg   <= bus.addr;
            addr_chg_reg <= (bus.addr != addr_q_reg);
        end
    end

    assign bus.data     = data_next;
    assign bus.data_q   = data_q_reg;
    assign bus.addr_chg = addr_chg_reg;

endmodule

// File: tb/tb_rom4_16x8.sv
// Directed bench for the hex-digit 7-segment ROM: table sweep without clock,
// registered copy, change strobe, async reset and the inverted/decimal-point variant.
module tb_rom4_16x8;

    logic sysclk;
    logic rst_n;
    logic clk_en;
    int   checks;
    int   errors;

    rom4_16x8_if bus ();
    rom4_16x8_if bus_inv ();

    rom4_16x8 u_dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    rom4_16x8 #(
        .INVERT  (1'b1),
        .DP_MASK (16'h0001)
    ) u_dut_inv (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus_inv)
    );

    // Hand-written segment table, entry i at index i.
    logic [7:0] exp_tab [16];

    initial begin
        sysclk = 1'b0;
        forever begin
            #5;
            if (clk_en) sysclk = ~sysclk;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        bus.addr     = 4'h0;
        bus_inv.addr = 4'h0;
        exp_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

        // Reset state with no clock.
        #3;
        check("rst_data_q", bus.data_q, 8'h00);
        check("rst_addr_chg", {7'b0, bus.addr_chg}, 8'h00);

        // 1: combinational sweep, clock stopped, reset held.
        for (int i = 0; i < 16; i++) begin
            bus.addr = 4'(i);
            #500;
            check($sformatf("sweep_%0h", i), bus.data, exp_tab[i]);
            $display("sweep addr=%h data=%h", bus.addr, bus.data);
            #500;
        end
        check("sweep_data_q_held", bus.data_q, 8'h00);

        // 2: clock running, release reset with addr=4.
        bus.addr = 4'h4;
        clk_en = 1'b1;
        tick();
        check("t2_data_q_in_reset", bus.data_q, 8'h00);
        check("t2_chg_in_reset", {7'b0, bus.addr_chg}, 8'h00);
        rst_n = 1'b1;
        tick();
        check("t2_data_q_release", bus.data_q, 8'h66);
        check("t2_chg_release", {7'b0, bus.addr_chg}, 8'h01);
        tick();
        check("t2_chg_stable", {7'b0, bus.addr_chg}, 8'h00);
        check("t2_data_q_stable", bus.data_q, 8'h66);
        $display("t2 data_q=%h addr_chg=%b", bus.data_q, bus.addr_chg);

        // 3: addr 3 -> 9 between edges.
        bus.addr = 4'h3;
        tick();
        tick();
        check("t3_data_q_3", bus.data_q, 8'h4F);
        bus.addr = 4'h9;
        #1;
        check("t3_data_now", bus.data, 8'h6F);
        check("t3_data_q_lag", bus.data_q, 8'h4F);
        tick();
        check("t3_data_q_9", bus.data_q, 8'h6F);
        check("t3_chg_pulse", {7'b0, bus.addr_chg}, 8'h01);
        tick();
        check("t3_chg_end", {7'b0, bus.addr_chg}, 8'h00);
        $display("t3 data=%h data_q=%h addr_chg=%b", bus.data, bus.data_q, bus.addr_chg);

        // 4: reset asserted mid-run with addr=A.
        bus.addr = 4'hA;
        tick();
        check("t4_data_q_pre", bus.data_q, 8'h77);
        check("t4_chg_pre", {7'b0, bus.addr_chg}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_data_q_async", bus.data_q, 8'h00);
        check("t4_chg_async", {7'b0, bus.addr_chg}, 8'h00);
        check("t4_data_in_reset", bus.data, 8'h77);
        tick();
        check("t4_data_q_held", bus.data_q, 8'h00);
        rst_n = 1'b1;
        tick();
        check("t4_data_q_reload", bus.data_q, 8'h77);
        check("t4_chg_reload", {7'b0, bus.addr_chg}, 8'h01);
        $display("t4 data=%h data_q=%h addr_chg=%b", bus.data, bus.data_q, bus.addr_chg);

        // 5: inverted variant with decimal point on address 0.
        bus_inv.addr = 4'h0;
        #1;
        check("t5_inv_addr0", bus_inv.data, 8'h40);
        bus_inv.addr = 4'h8;
        #1;
        check("t5_inv_addr8", bus_inv.data, 8'h80);
        tick();
        check("t5_inv_data_q", bus_inv.data_q, 8'h80);
        $display("t5 inv data=%h data_q=%h", bus_inv.data, bus_inv.data_q);

        // 6: increment every cycle across the F->0 wrap.
        bus.addr = 4'hE;
        tick();
        tick();
        check("t6_chg_idle", {7'b0, bus.addr_chg}, 8'h00);
        for (int s = 0; s < 3; s++) begin
            logic [3:0] a;
            logic [3:0] prev;
            a    = 4'(4'hF + s);
            prev = 4'(a - 4'h1);
            bus.addr = a;
            #1;
            check($sformatf("t6_lag_%0h", a), bus.data_q, exp_tab[prev]);
            tick();
            check($sformatf("t6_data_q_%0h", a), bus.data_q, exp_tab[a]);
            check($sformatf("t6_chg_%0h", a), {7'b0, bus.addr_chg}, 8'h01);
            $display("t6 addr=%h data_q=%h addr_chg=%b", bus.addr, bus.data_q, bus.addr_chg);
        end
        tick();
        check("t6_chg_hold", {7'b0, bus.addr_chg}, 8'h00);
        check("t6_data_q_hold", bus.data_q, 8'h06);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
